sram_wr_router: RTL



---
 rtl/sram_wr_router.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/sram_wr_router.sv
// Routes writes from NSRC queued sources to a residual SRAM port and a global SRAM port.
// Each source owns a small FIFO; a 2-bit route table picks the destination per source
// and each destination runs its own round-robin arbiter. Write outputs are registered.
module sram_wr_router #(
    parameter int DATA_W = 8,
    parameter int LANES  = 16,
    parameter int DEPTH  = 256,
    parameter int NSRC   = 2,
    parameter int FDEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(LANES)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_vld,
    input  logic [2*NSRC-1:0]             cfg_route,
    input  logic [AW+LW:0]                cfg_words,
    input  logic [NSRC-1:0]               src_vld,
    output logic [NSRC-1:0]               src_rdy,
    input  logic [NSRC-1:0]               src_byte,
    input  logic [NSRC*LANES*DATA_W-1:0]  src_data,
    input  logic [NSRC*(AW+LW)-1:0]       src_addr,
    output logic                          res_wen,
    output logic                          res_byte_flag,
    output logic [AW+LW-1:0]              res_waddr,
    output logic [LANES*DATA_W-1:0]       res_wdata,
    output logic                          glb_wen,
    output logic [AW-1:0]                 glb_waddr,
    output logic [LANES*DATA_W-1:0]       glb_wdata,
    output logic                          finish,
    output logic                          route_err
);

    localparam int WW  = LANES * DATA_W;
    localparam int AWL = AW + LW;
    localparam int EW  = WW + AWL + 1;  // {data, addr, byte}
    localparam int IW  = $clog2(FDEPTH);
    localparam int PW  = IW + 1;
    localparam int SW  = $clog2(NSRC);
    localparam int CW  = AWL + 1;

    // Round-robin pick: first requester at or after ptr, wrapping.
    function automatic logic [SW-1:0] rr_pick(input logic [NSRC-1:0] req,
                                              input logic [SW-1:0] ptr);
        logic [SW-1:0] sel;
        logic          found;
        int            idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            idx = (int'(ptr) + k) % NSRC;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = SW'(idx);
            end
        end
        return sel;
    endfunction

    function automatic logic [SW-1:0] rr_next(input logic [SW-1:0] sel);
        return (int'(sel) == NSRC - 1) ? '0 : sel + SW'(1);
    endfunction

    logic [EW-1:0]           mem_q [NSRC][FDEPTH];
    logic [NSRC-1:0][PW-1:0] wptr_q, rptr_q;
    logic                    rdy_en_q;
    logic [2*NSRC-1:0]       route_q;
    logic [CW-1:0]           words_q, cnt_q, cnt_d;
    logic [SW-1:0]           res_ptr_q, glb_ptr_q, drop_ptr_q;
    logic                    res_wen_q, res_byte_q, glb_wen_q, finish_q, route_err_q;
    logic [AWL-1:0]          res_waddr_q;
    logic [AW-1:0]           glb_waddr_q;
    logic [WW-1:0]           res_wdata_q, glb_wdata_q;

    logic [NSRC-1:0]         full, empty, push, pop;
    logic [NSRC-1:0]         res_req, glb_req, drop_req;
    logic [EW-1:0]           head [NSRC];
    logic [EW-1:0]           entry_in [NSRC];
    logic [SW-1:0]           res_sel, glb_sel, drop_sel;
    logic                    res_any, glb_any, drop_any;
    logic [EW-1:0]           res_ent, glb_ent;
    logic                    res_issue, glb_issue, glb_bad, fin;
    logic [1:0]              nwr;
    logic [CW:0]             sum;
    logic                    res_byte_d;
    logic [AWL-1:0]          res_waddr_d;
    logic [AW-1:0]           glb_waddr_d;
    logic [WW-1:0]           res_wdata_d, glb_wdata_d;

    // Ready is held low until the first cycle after reset is released.
    assign src_rdy = rdy_en_q ? ~full : '0;
    assign push    = src_vld & src_rdy;

    // FIFO status, head entries and per-destination requests.
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            empty[i]    = (wptr_q[i] == rptr_q[i]);
            full[i]     = (wptr_q[i][IW] != rptr_q[i][IW]) &&
                          (wptr_q[i][IW-1:0] == rptr_q[i][IW-1:0]);
            head[i]     = mem_q[i][rptr_q[i][IW-1:0]];
            entry_in[i] = {src_data[i*WW +: WW], src_addr[i*AWL +: AWL], src_byte[i]};
            res_req[i]  = !empty[i] && (route_q[2*i +: 2] == 2'd1);
            glb_req[i]  = !empty[i] && (route_q[2*i +: 2] == 2'd2);
            drop_req[i] = !empty[i] && (route_q[2*i +: 2] == 2'd0 ||
                                        route_q[2*i +: 2] == 2'd3);
        end
    end

    // Arbitration, pops, write issue and the finish counter.
    always_comb begin
        res_any  = |res_req;
        glb_any  = |glb_req;
        drop_any = |drop_req;
        res_sel  = rr_pick(res_req, res_ptr_q);
        glb_sel  = rr_pick(glb_req, glb_ptr_q);
        drop_sel = rr_pick(drop_req, drop_ptr_q);
        for (int i = 0; i < NSRC; i++) begin
            pop[i] = (res_any  && res_sel  == SW'(i)) ||
                     (glb_any  && glb_sel  == SW'(i)) ||
                     (drop_any && drop_sel == SW'(i));
        end
        res_ent   = head[res_sel];
        glb_ent   = head[glb_sel];
        res_issue = res_any;
        glb_issue = glb_any && !glb_ent[0];
        glb_bad   = glb_any && glb_ent[0];

        nwr = {1'b0, res_issue} + {1'b0, glb_issue};
        sum = {1'b0, cnt_q} + {{(CW-1){1'b0}}, nwr};
        fin = (words_q != '0) && (sum >= {1'b0, words_q});
        cnt_d = fin ? CW'(sum - {1'b0, words_q}) : CW'(sum);

        res_byte_d  = 1'b0;
        res_waddr_d = '0;
        res_wdata_d = '0;
        glb_waddr_d = '0;
        glb_wdata_d = '0;
        if (res_issue) begin
            res_byte_d  = res_ent[0];
            res_waddr_d = res_ent[AWL:1];
            res_wdata_d = res_ent[0] ? WW'(res_ent[AWL+1 +: DATA_W]) : res_ent[EW-1:AWL+1];
        end
        if (glb_issue) begin
            glb_waddr_d = glb_ent[AW:1];
            glb_wdata_d = glb_ent[EW-1:AWL+1];
        end
    end

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NSRC; i++) begin
            if (push[i]) mem_q[i][wptr_q[i][IW-1:0]] <= entry_in[i];
        end
    end

    // Control state, counters and registered write outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdy_en_q    <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            route_q     <= '0;
            words_q     <= '0;
            cnt_q       <= '0;
            res_ptr_q   <= '0;
            glb_ptr_q   <= '0;
            drop_ptr_q  <= '0;
            res_wen_q   <= 1'b0;
            res_byte_q  <= 1'b0;
            res_waddr_q <= '0;
            res_wdata_q <= '0;
            glb_wen_q   <= 1'b0;
            glb_waddr_q <= '0;
            glb_wdata_q <= '0;
            finish_q    <= 1'b0;
            route_err_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            for (int i = 0; i < NSRC; i++) begin
                if (push[i]) wptr_q[i] <= wptr_q[i] + PW'(1);
                if (pop[i])  rptr_q[i] <= rptr_q[i] + PW'(1);
            end
            if (res_any)  res_ptr_q  <= rr_next(res_sel);
            if (glb_any)  glb_ptr_q  <= rr_next(glb_sel);
            if (drop_any) drop_ptr_q <= rr_next(drop_sel);
            // A config load restarts counting; writes issued this cycle are not counted.
            if (cfg_vld) begin
                route_q  <= cfg_route;
                words_q  <= cfg_words;
                cnt_q    <= '0;
                finish_q <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                finish_q <= fin;
            end
            res_wen_q   <= res_issue;
            res_byte_q  <= res_byte_d;
            res_waddr_q <= res_waddr_d;
            res_wdata_q <= res_wdata_d;
            glb_wen_q   <= glb_issue;
            glb_waddr_q <= glb_waddr_d;
            glb_wdata_q <= glb_wdata_d;
            route_err_q <= route_err_q | glb_bad;
        end
    end

    assign res_wen       = res_wen_q;
    assign res_byte_flag = res_byte_q;
    assign res_waddr     = res_waddr_q;
    assign res_wdata     = res_wdata_q;
    assign glb_wen       = glb_wen_q;
    assign glb_waddr     = glb_waddr_q;
    assign glb_wdata     = glb_wdata_q;
    assign finish        = finish_q;
    assign route_err     = route_err_q;

endmodule
